// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
// Stage bit positions, FSM encoding and default latencies.
package pipe_hazard_ctrl_pkg;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;

    localparam int MDU_LAT_DEF     = 8;
    localparam int MEM_TIMEOUT_DEF = 256;

    localparam logic [3:0] M_PC    = 4'(1 << STG_PC);
    localparam logic [3:0] M_IFID  = 4'(1 << STG_IFID);
    localparam logic [3:0] M_IDEX  = 4'(1 << STG_IDEX);
    localparam logic [3:0] M_EXMEM = 4'(1 << STG_EXMEM);
    localparam logic [3:0] M_ALL   = M_PC | M_IFID | M_IDEX | M_EXMEM;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_watchdog.sv
// Memory-wait watchdog: saturating run-length counter
// of consecutive wait cycles plus a sticky timeout flag.
module hazard_wait_watchdog #(
    parameter int MEM_TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_wait_i,
    output logic mem_timeout_o
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] CNT_MAX = WW'(MEM_TIMEOUT);
    localparam logic [WW-1:0] CNT_TRIP = WW'(MEM_TIMEOUT - 1);

    logic [WW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt      <= '0;
            mem_timeout_o <= 1'b0;
        end else if (mem_wait_i) begin
            if (wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_TRIP)
                mem_timeout_o <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Owns the MDU occupancy FSM and the memory-wait watchdog.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int MDU_LAT     = MDU_LAT_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_use_i,
    input  logic       branch_taken_i,
    input  logic       annul_slot_i,
    input  logic       mdu_start_i,
    input  logic       mem_wait_i,
    output logic [3:0] stall_C,
    output logic [3:0] flush_C,
    output logic       slot_flush,
    output logic       busy_o,
    output logic       mem_timeout_o
);

    localparam int CW = $clog2(MDU_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 2);

    hz_state_t     state, state_nxt;
    logic [CW-1:0] mdu_cnt, mdu_cnt_nxt;
    logic          mdu_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        if (!mem_wait_i) begin
            unique case (state)
                RUN: begin
                    if (mdu_start_i) begin
                        state_nxt   = MDU_BUSY;
                        mdu_cnt_nxt = CNT_INIT;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt == '0)
                        state_nxt = RUN;
                    else
                        mdu_cnt_nxt = mdu_cnt - 1'b1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // The start cycle already occupies EX, so it stalls like a busy cycle.
    assign mdu_hold = (state == MDU_BUSY) || mdu_start_i;

    always_comb begin
        stall_C    = '0;
        flush_C    = '0;
        slot_flush = 1'b0;
        if (!rst) begin
            if (mem_wait_i) begin
                stall_C = M_ALL;
            end else if (mdu_hold) begin
                stall_C = M_PC | M_IFID | M_IDEX;
                flush_C = M_EXMEM;
            end else if (branch_taken_i) begin
                flush_C = M_IFID | M_IDEX;
            end else if (load_use_i) begin
                stall_C = M_PC | M_IFID;
                flush_C = M_IDEX;
            end else if (annul_slot_i) begin
                slot_flush = 1'b1;
            end
        end
    end

    assign busy_o = (state == MDU_BUSY) && !rst;

    hazard_wait_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wdog (
        .clk          (clk),
        .rst          (rst),
        .mem_wait_i   (mem_wait_i),
        .mem_timeout_o(mem_timeout_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl against a
// cycle-count reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 8;
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_use_i = 1'b0;
    logic       branch_taken_i = 1'b0;
    logic       annul_slot_i = 1'b0;
    logic       mdu_start_i = 1'b0;
    logic       mem_wait_i = 1'b0;
    logic [3:0] stall_C;
    logic [3:0] flush_C;
    logic       slot_flush;
    logic       busy_o;
    logic       mem_timeout_o;

    pipe_hazard_ctrl #(
        .MDU_LAT    (LAT),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_use_i    (load_use_i),
        .branch_taken_i(branch_taken_i),
        .annul_slot_i  (annul_slot_i),
        .mdu_start_i   (mdu_start_i),
        .mem_wait_i    (mem_wait_i),
        .stall_C       (stall_C),
        .flush_C       (flush_C),
        .slot_flush    (slot_flush),
        .busy_o        (busy_o),
        .mem_timeout_o (mem_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] stall;
        logic [3:0] flush;
        logic       slot;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pushed = 0;
    int   popped = 0;
    bit   done = 0;

    // Reference model: remaining busy cycles, wait run length, sticky flag.
    int   m_rem = 0;
    int   m_run = 0;
    bit   m_tmo = 0;

    task automatic step(input bit r, input bit lu, input bit br,
                        input bit an, input bit ms, input bit mw);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        load_use_i = lu;
        branch_taken_i = br;
        annul_slot_i = an;
        mdu_start_i = ms;
        mem_wait_i = mw;
        e = '0;
        if (r) begin
            m_rem = 0;
            m_run = 0;
            m_tmo = 0;
        end else begin
            e.busy = (m_rem > 0);
            e.tmo = m_tmo;
            if (mw) begin
                e.stall = 4'b1111;
            end else if (m_rem > 0 || ms) begin
                e.stall = 4'b0111;
                e.flush = 4'b1000;
            end else if (br) begin
                e.flush = 4'b0110;
            end else if (lu) begin
                e.stall = 4'b0011;
                e.flush = 4'b0100;
            end else if (an) begin
                e.slot = 1'b1;
            end
            if (!mw) begin
                if (m_rem > 0) m_rem = m_rem - 1;
                else if (ms) m_rem = LAT - 1;
            end
            m_run = mw ? m_run + 1 : 0;
            if (m_run >= TMO) m_tmo = 1;
        end
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                popped++;
                a = {stall_C, flush_C, slot_flush, busy_o, mem_timeout_o};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL cyc%0d stall=%b/%b flush=%b/%b slot=%b/%b busy=%b/%b tmo=%b/%b",
                             popped, a.stall, e.stall, a.flush, e.flush,
                             a.slot, e.slot, a.busy, e.busy, a.tmo, e.tmo);
                end
            end
        end
    end

    initial begin : driver
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        idle(1);
        step(0, 0, 0, 0, 1, 0);
        idle(LAT + 1);
        step(0, 0, 0, 0, 1, 0);
        idle(3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        idle(LAT);
        step(0, 0, 0, 0, 1, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < TMO; i++) step(0, 0, 0, 0, 0, 1);
        idle(5);
        step(1, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LAT + 1; i++) step(0, 0, 0, 0, 1, 0);
        idle(2);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(99) < 2),
                 ($urandom_range(99) < 30),
                 ($urandom_range(99) < 20),
                 ($urandom_range(99) < 30),
                 ($urandom_range(99) < 10),
                 ($urandom_range(99) < 25));
        end
        idle(2);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (popped != pushed || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain popped=%0d pushed=%0d", popped, pushed);
        end
        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : timeout_guard
        #500000;
        if (!done) begin
            $display("FAIL watchdog time limit popped=%0d", popped);
            $fatal(1, "time limit");
        end
    end

endmodule
